pmp_check_pipe: RTL and testbench
=================================

PMP_CHECK_PIPE -- requirements
Module: pmp_check_pipe

Interface
REQ-001 SHALL have parameter PLEN, default 34, physical address width in bits.
REQ-002 SHALL have parameter PMP_LEN, default 32, pmpaddr register width (holds address bits [PMP_LEN+1:2]).
REQ-003 SHALL have parameter NR_ENTRIES, default 16, number of PMP entries, legal range 1..16.
REQ-004 SHALL have ports: clk_i  in  1  clock; rst_i  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: cfg_we_i  in  1  cfg write strobe; cfg_idx_i  in  $clog2(NR_ENTRIES) (min 1)  entry index; cfg_data_i  in  8  pmpcfg {L,2'b0,A[1:0],X,W,R}.
REQ-006 SHALL have ports: addr_we_i  in  1  pmpaddr write strobe; addr_idx_i  in  $clog2(NR_ENTRIES) (min 1)  entry index; addr_data_i  in  PMP_LEN  pmpaddr value.
REQ-007 SHALL have ports: req_valid_i  in  1; req_ready_o  out  1; req_addr_i  in  PLEN; req_access_i  in  3  one-hot {X,W,R}; req_priv_i  in  2  (0=U,1=S,3=M); req_id_i  in  4  tag.
REQ-008 SHALL have ports: rsp_valid_o  out  1; rsp_ready_i  in  1; rsp_allow_o  out  1; rsp_match_o  out  1  some entry matched; rsp_idx_o  out  4  winning entry; rsp_id_o  out  4  echoed tag.

Function
REQ-009 SHALL hold per-entry cfg (8 bits) and addr (PMP_LEN bits) registers; writes take effect from the edge at which the strobe is sampled.
REQ-010 SHALL ignore cfg/addr writes to an entry whose L=1; SHALL ignore addr write to entry i when entry i+1 has L=1 and A=TOR.
REQ-011 SHALL ignore writes with index >= NR_ENTRIES; simultaneous cfg and addr writes SHALL both apply independently.
REQ-012 SHALL decode A: 0 OFF (never matches), 1 TOR, 2 NA4, 3 NAPOT; byte address = {addr,2'b00}, zero-extended/truncated to PLEN.
REQ-013 TOR SHALL match when prev_base <= req_addr < this_base, unsigned; prev_base of entry 0 is 0; this_base <= prev_base yields no match.
REQ-014 NA4 SHALL match when req_addr[PLEN-1:2] equals the entry address.
REQ-015 NAPOT: k = count of trailing ones in addr; region size 2^(k+3) bytes; SHALL match when req_addr and base agree on bits above bit k+2; all-ones addr matches whole space.
REQ-016 Lowest-index matching entry SHALL win; rsp_idx_o = that index, rsp_match_o = 1.
REQ-017 Allow rule: match and priv=M and L=0 -> allow; match otherwise -> allow iff (req_access_i & {X,W,R}) != 0; no match -> allow iff priv=M.
REQ-018 Pipeline SHALL be two stages: stage A (request capture) and stage R (result register driving rsp_*).
REQ-019 Request accepted on edge where req_valid_i & req_ready_o; match evaluated during the following cycle against cfg/addr values of that cycle; result loaded into R at next edge; rsp_valid_o high 2 edges after acceptance when unstalled.
REQ-020 Stage R SHALL load when empty or rsp_ready_i=1; rsp_* SHALL hold stable while rsp_valid_o & !rsp_ready_i.
REQ-021 req_ready_o = !A_valid | (R empty | rsp_ready_i); sustained throughput one request per cycle with rsp_ready_i=1.
REQ-022 A config write in the same cycle a request sits in stage A SHALL NOT affect that request's result.
REQ-023 rsp_idx_o and rsp_match_o SHALL be 0 when no entry matches.

Reset
REQ-024 On rst_i=1 at an edge: all cfg=0 (OFF, unlocked), all addr=0, both stages empty, rsp_valid_o=0, rsp_allow_o/rsp_match_o/rsp_idx_o/rsp_id_o=0.
REQ-025 req_ready_o SHALL be 1 in the first cycle after reset deasserts; reset during in-flight requests SHALL discard them with no response.
REQ-026 Reset SHALL clear lock bits.

Verification
REQ-027 Layered NAPOT: entry2 addr=0x65F (0x1900, 256 B) RWX; read U 0x19BA -> allow=1, idx=2; add entry1 addr=0x66D (0x19B0, 16 B) perms 0 -> allow=0, idx=1; add entry0 addr=0x66E (0x19B8, 8 B) R -> allow=1, idx=0.
REQ-028 TOR: entry0 addr=0x400 OFF, entry1 addr=0x800 TOR R; U reads 0x1000 -> allow idx1, 0x1FFF -> allow, 0x2000 -> deny match=0, 0x0FFC -> deny.
REQ-029 Lock: entry3 cfg L=1 NA4 R addr=0x100; write cfg=0 then addr=0x200 -> both ignored; M write to 0x400 -> deny idx=3; M write to 0x404 -> allow match=0.
REQ-030 Backpressure: 4 back-to-back requests, rsp_ready_i=0 for 3 cycles -> req_ready_o drops after 2 accepts, rsp_* stable, all 4 responses in order with correct ids.
REQ-031 Reset mid-flight: 2 requests in pipeline, rst_i for 1 cycle -> no responses, rsp_valid_o=0, cfg OFF, req_ready_o=1 next cycle.

Source files
------------

// File: rtl/pmp_check_pipe.sv
// PMP permission checker: per-entry cfg/addr register file plus a two-stage
// request pipeline (A: capture, R: result) with valid/ready on both sides.
module pmp_check_pipe #(
  parameter int PLEN       = 34,
  parameter int PMP_LEN    = 32,
  parameter int NR_ENTRIES = 16,
  localparam int IDX_W     = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_we_i,
  input  logic [IDX_W-1:0]   cfg_idx_i,
  input  logic [7:0]         cfg_data_i,
  input  logic               addr_we_i,
  input  logic [IDX_W-1:0]   addr_idx_i,
  input  logic [PMP_LEN-1:0] addr_data_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [PLEN-1:0]    req_addr_i,
  input  logic [2:0]         req_access_i,
  input  logic [1:0]         req_priv_i,
  input  logic [3:0]         req_id_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic               rsp_allow_o,
  output logic               rsp_match_o,
  output logic [3:0]         rsp_idx_o,
  output logic [3:0]         rsp_id_o
);

  localparam int AW = PMP_LEN + 2;
  localparam int WW = (PLEN > AW) ? PLEN : AW;
  localparam logic [1:0] A_TOR = 2'd1, A_NA4 = 2'd2, A_NAPOT = 2'd3;

  logic [7:0]         cfg_q  [NR_ENTRIES];
  logic [PMP_LEN-1:0] addr_q [NR_ENTRIES];
  logic [NR_ENTRIES:0] tor_lock;
  logic [NR_ENTRIES-1:0] addr_wr_ok;

  // pmpaddr holds address bits [PMP_LEN+1:2]; widen or trim to PLEN
  function automatic logic [PLEN-1:0] to_byte(input logic [PMP_LEN-1:0] a);
    logic [WW-1:0] w;
    w = WW'({a, 2'b00});
    return w[PLEN-1:0];
  endfunction

  // tor_lock[NR_ENTRIES] stays 0 so the top entry has no upper neighbour
  always_comb begin
    tor_lock   = '0;
    addr_wr_ok = '0;
    for (int i = 0; i < NR_ENTRIES; i++)
      tor_lock[i] = cfg_q[i][7] && (cfg_q[i][4:3] == A_TOR);
    for (int i = 0; i < NR_ENTRIES; i++)
      addr_wr_ok[i] = !cfg_q[i][7] && !tor_lock[i+1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        cfg_q[i]  <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        if (cfg_we_i && (int'(cfg_idx_i) == i) && !cfg_q[i][7])
          cfg_q[i] <= cfg_data_i;
        if (addr_we_i && (int'(addr_idx_i) == i) && addr_wr_ok[i])
          addr_q[i] <= addr_data_i;
      end
    end
  end

  logic            a_valid;
  logic [PLEN-1:0] a_addr;
  logic [2:0]      a_access;
  logic [1:0]      a_priv;
  logic [3:0]      a_id;
  logic            r_load;
  logic            accept;

  assign r_load      = !rsp_valid_o || rsp_ready_i;
  assign req_ready_o = !a_valid || r_load;
  assign accept      = req_valid_i && req_ready_o;

  logic            hit;
  logic [3:0]      hit_idx;
  logic [7:0]      hit_cfg;
  logic            allow;
  logic [PLEN-1:0] base, prev, dc;
  logic            m;

  // ascending scan, first hit latched so the lowest index wins
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_cfg = '0;
    prev    = '0;
    base    = '0;
    dc      = '0;
    m       = 1'b0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      base = to_byte(addr_q[i]);
      // don't-care byte bits of a NAPOT region: trailing ones, their zero, 2 LSBs
      dc   = PLEN'({addr_q[i] ^ (addr_q[i] + PMP_LEN'(1)), 2'b11});
      case (cfg_q[i][4:3])
        A_TOR:   m = (a_addr >= prev) && (a_addr < base);
        A_NA4:   m = (a_addr[PLEN-1:2] == base[PLEN-1:2]);
        A_NAPOT: m = (&addr_q[i]) || (((a_addr ^ base) & ~dc) == '0);
        default: m = 1'b0;
      endcase
      if (m && !hit) begin
        hit     = 1'b1;
        hit_idx = 4'(i);
        hit_cfg = cfg_q[i];
      end
      prev = base;
    end
  end

  always_comb begin
    allow = (a_priv == 2'd3);
    if (hit)
      allow = ((a_priv == 2'd3) && !hit_cfg[7]) || ((a_access & hit_cfg[2:0]) != 3'b000);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_valid     <= 1'b0;
      a_addr      <= '0;
      a_access    <= '0;
      a_priv      <= '0;
      a_id        <= '0;
      rsp_valid_o <= 1'b0;
      rsp_allow_o <= 1'b0;
      rsp_match_o <= 1'b0;
      rsp_idx_o   <= '0;
      rsp_id_o    <= '0;
    end else begin
      if (accept) begin
        a_valid  <= 1'b1;
        a_addr   <= req_addr_i;
        a_access <= req_access_i;
        a_priv   <= req_priv_i;
        a_id     <= req_id_i;
      end else if (r_load) begin
        a_valid  <= 1'b0;
      end
      if (r_load) begin
        rsp_valid_o <= a_valid;
        if (a_valid) begin
          rsp_allow_o <= allow;
          rsp_match_o <= hit;
          rsp_idx_o   <= hit_idx;
          rsp_id_o    <= a_id;
        end
      end
    end
  end

endmodule

// File: tb/tb_pmp_check_pipe.sv
// Directed bench for pmp_check_pipe: expected responses queued at drive time,
// popped and compared by a monitor as each response handshakes.
module tb_pmp_check_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we, addr_we;
  logic [3:0]  cfg_idx, addr_idx;
  logic [7:0]  cfg_data;
  logic [31:0] addr_data;
  logic        req_valid, req_ready;
  logic [33:0] req_addr;
  logic [2:0]  req_access;
  logic [1:0]  req_priv;
  logic [3:0]  req_id;
  logic        rsp_valid, rsp_ready, rsp_allow, rsp_match;
  logic [3:0]  rsp_idx, rsp_id;

  always #5 clk = ~clk;

  pmp_check_pipe dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_data_i(cfg_data),
    .addr_we_i(addr_we), .addr_idx_i(addr_idx), .addr_data_i(addr_data),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_access_i(req_access), .req_priv_i(req_priv), .req_id_i(req_id),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_allow_o(rsp_allow),
    .rsp_match_o(rsp_match), .rsp_idx_o(rsp_idx), .rsp_id_o(rsp_id)
  );

  typedef struct packed {
    logic       allow;
    logic       match;
    logic [3:0] idx;
    logic [3:0] id;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t got, want;
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [2:0] RD = 3'b001, WR = 3'b010, EX = 3'b100;
  localparam logic [1:0] PU = 2'd0, PM = 2'd3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      got = rsp_t'({rsp_allow, rsp_match, rsp_idx, rsp_id});
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp_queue_depth", 32'(exp_q.size()), 32'd1);
      end else begin
        want = exp_q.pop_front();
        chk($sformatf("rsp_id%0d{allow,match,idx,id}", want.id), 32'(got), 32'(want));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input int idx, input logic [7:0] d);
    cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic addr_wr(input int idx, input logic [31:0] d);
    addr_we = 1'b1; addr_idx = 4'(idx); addr_data = d;
    step();
    addr_we = 1'b0;
  endtask

  task automatic wr_both(input int idx, input logic [7:0] c, input logic [31:0] a);
    cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_data = c;
    addr_we = 1'b1; addr_idx = 4'(idx); addr_data = a;
    step();
    cfg_we = 1'b0; addr_we = 1'b0;
  endtask

  task automatic req_drive(input logic [33:0] a, input logic [2:0] acc, input logic [1:0] pv,
                           input logic [3:0] id, input logic ea, input logic em,
                           input logic [3:0] ei);
    req_valid = 1'b1; req_addr = a; req_access = acc; req_priv = pv; req_id = id;
    exp_q.push_back(rsp_t'({ea, em, ei, id}));
  endtask

  task automatic req_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("req_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic req(input logic [33:0] a, input logic [2:0] acc, input logic [1:0] pv,
                     input logic [3:0] id, input logic ea, input logic em, input logic [3:0] ei);
    req_drive(a, acc, pv, id, ea, em, ei);
    req_accept();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; cfg_we = 1'b0; addr_we = 1'b0;
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; addr_we = 1'b0; cfg_idx = '0; addr_idx = '0;
    cfg_data = '0; addr_data = '0; req_valid = 1'b0; req_addr = '0;
    req_access = '0; req_priv = '0; req_id = '0; rsp_ready = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_fields", 32'({rsp_allow, rsp_match, rsp_idx, rsp_id}), 32'd0);
    step();

    // layered NAPOT regions
    cfg_wr(2, 8'h1F); addr_wr(2, 32'h65F);
    req(34'h19BA, RD, PU, 4'd1, 1'b1, 1'b1, 4'd2);
    cfg_wr(1, 8'h18); addr_wr(1, 32'h66D);
    req(34'h19BA, RD, PU, 4'd2, 1'b0, 1'b1, 4'd1);
    wr_both(0, 8'h19, 32'h66E);
    req(34'h19BA, RD, PU, 4'd3, 1'b1, 1'b1, 4'd0);
    req(34'h19B4, RD, PU, 4'd4, 1'b0, 1'b1, 4'd1);
    req(34'h1950, EX, PU, 4'd5, 1'b1, 1'b1, 4'd2);
    req(34'h1A00, RD, PU, 4'd6, 1'b0, 1'b0, 4'd0);
    req(34'h1A00, RD, PM, 4'd7, 1'b1, 1'b0, 4'd0);
    drain();

    // TOR
    do_reset();
    addr_wr(0, 32'h400); addr_wr(1, 32'h800); cfg_wr(1, 8'h09);
    req(34'h1000, RD, PU, 4'd1, 1'b1, 1'b1, 4'd1);
    req(34'h1FFF, RD, PU, 4'd2, 1'b1, 1'b1, 4'd1);
    req(34'h2000, RD, PU, 4'd3, 1'b0, 1'b0, 4'd0);
    req(34'h0FFC, RD, PU, 4'd4, 1'b0, 1'b0, 4'd0);
    req(34'h1000, WR, PU, 4'd5, 1'b0, 1'b1, 4'd1);
    req(34'h1000, WR, PM, 4'd6, 1'b1, 1'b1, 4'd1);
    // cfg write in the request's evaluation cycle must not change its result
    req(34'h1000, RD, PU, 4'd7, 1'b1, 1'b1, 4'd1);
    cfg_wr(1, 8'h08);
    req(34'h1000, RD, PU, 4'd8, 1'b0, 1'b1, 4'd1);
    // inverted TOR bounds never match
    addr_wr(2, 32'h300); cfg_wr(2, 8'h0F);
    req(34'h0800, RD, PU, 4'd9, 1'b0, 1'b0, 4'd0);
    drain();

    // locking
    do_reset();
    wr_both(3, 8'h91, 32'h100);
    cfg_wr(3, 8'h00); addr_wr(3, 32'h200);
    req(34'h0400, WR, PM, 4'd1, 1'b0, 1'b1, 4'd3);
    req(34'h0404, WR, PM, 4'd2, 1'b1, 1'b0, 4'd0);
    req(34'h0400, RD, PM, 4'd3, 1'b1, 1'b1, 4'd3);
    req(34'h0800, RD, PU, 4'd4, 1'b0, 1'b0, 4'd0);
    addr_wr(4, 32'h80); addr_wr(5, 32'h90); cfg_wr(5, 8'h89);
    addr_wr(4, 32'h88); addr_wr(5, 32'hA0);
    req(34'h0210, RD, PU, 4'd5, 1'b1, 1'b1, 4'd5);
    req(34'h0250, RD, PU, 4'd6, 1'b0, 1'b0, 4'd0);
    drain();

    // backpressure with entry 0 covering the whole space, locked
    do_reset();
    addr_wr(0, 32'hFFFF_FFFF); cfg_wr(0, 8'h99);
    rsp_ready = 1'b0;
    req(34'h0_0000_0000, RD, PU, 4'd1, 1'b1, 1'b1, 4'd0);
    req(34'h3_FFFF_FFFC, RD, PU, 4'd2, 1'b1, 1'b1, 4'd0);
    req_drive(34'h1234, WR, PU, 4'd3, 1'b0, 1'b1, 4'd0);
    @(negedge clk);
    chk("bp_req_ready_low", 32'(req_ready), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_rsp_hold", 32'({rsp_valid, rsp_allow, rsp_match, rsp_idx, rsp_id}),
          32'({1'b1, 1'b1, 1'b1, 4'd0, 4'd1}));
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    req_accept();
    req(34'h2_0000_0000, EX, PM, 4'd4, 1'b0, 1'b1, 4'd0);
    req(34'h40, RD, PU, 4'd5, 1'b1, 1'b1, 4'd0);
    req(34'h44, RD, PU, 4'd6, 1'b1, 1'b1, 4'd0);
    drain();

    // reset with two requests in flight
    rsp_ready = 1'b0;
    req(34'h40, RD, PU, 4'd7, 1'b1, 1'b1, 4'd0);
    req(34'h80, RD, PU, 4'd8, 1'b1, 1'b1, 4'd0);
    do_reset();
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_rsp_fields", 32'({rsp_allow, rsp_match, rsp_idx, rsp_id}), 32'd0);
    step();
    rsp_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    step();
    req(34'h40, RD, PU, 4'd9, 1'b0, 1'b0, 4'd0);
    // lock cleared by reset: entry 0 reprogrammable
    addr_wr(0, 32'hFFFF_FFFF); cfg_wr(0, 8'h1C);
    req(34'h40, RD, PU, 4'd10, 1'b0, 1'b1, 4'd0);
    req(34'h40, EX, PU, 4'd11, 1'b1, 1'b1, 4'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
